// File: rtl/regq_pkg.sv
// Shared types and default sizing for the register write queue.
// Build option REGQ_BYPASS_EN is consumed by reg_write_queue, not here.
package regq_pkg;

    localparam int REGQ_WIDTH = 32;
    localparam int REGQ_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } regq_state_e;

endpackage

// File: rtl/reg_write_queue_sync_fifo.sv
// Power-of-two circular FIFO with an occupancy counter.
// Pointers wrap freely; the counter is what tells full from empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
        else if (!push_i && pop_i) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset: the counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);

    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/reg_write_queue.sv
// Sequencer in front of the storage register: queues words and arbitrates
// write commits against read requests. Option REGQ_BYPASS_EN lets a word skip an empty FIFO.
module reg_write_queue
    import regq_pkg::*;
#(
    parameter int WIDTH = REGQ_WIDTH,
    parameter int DEPTH = REGQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] reg_in,
    output logic             reg_write,
    output logic             reg_read,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    regq_state_e      state_q, state_d;
    logic [WIDTH-1:0] reg_in_q, reg_in_d;
    logic             rd_blk_q, rd_blk_d;

    logic             push_acc;
    logic             byp;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] head;

    assign in_ready = !full;
    assign push_acc = in_valid && in_ready;

    always_comb begin
        state_d = IDLE;
        byp     = 1'b0;
        if (rd_req && !rd_blk_q) begin
            state_d = READ;
        end else if (!empty) begin
            state_d = WRITE;
        end
`ifdef REGQ_BYPASS_EN
        else if (push_acc) begin
            state_d = WRITE;
            byp     = 1'b1;
        end
`endif

        fifo_push = push_acc && !byp;
        fifo_pop  = (state_d == WRITE) && !byp;

        reg_in_d = reg_in_q;
        if (state_d == WRITE) reg_in_d = byp ? in_data : head;

        // Once a request is served it stays blocked until the consumer drops rd_req.
        rd_blk_d = rd_req && (rd_blk_q || (state_d == READ));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            reg_in_q <= '0;
            rd_blk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_in_q <= reg_in_d;
            rd_blk_q <= rd_blk_d;
        end
    end

    assign reg_write = (state_q == WRITE);
    assign reg_read  = (state_q == READ);
    assign rd_ack    = (state_q == READ);
    assign reg_in    = reg_in_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (fifo_push),
        .push_data_i (in_data),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: accepted words are queued and
// matched against every reg_write strobe; scenario tasks check timing inline.
module tb_reg_write_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef REGQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             rd_req;
    logic             rd_ack;
    logic [WIDTH-1:0] reg_in;
    logic             reg_write;
    logic             reg_read;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];

    reg_write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .reg_in    (reg_in),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each write strobe first, then record a push for the coming edge.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (reg_write) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_stale_write: reg_in=%0d written, no word expected", reg_in);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_in !== e) begin
                        n_fail++;
                        $display("FAIL sb_order: reg_in=%0d expected %0d", reg_in, e);
                    end
                end
            end
            if (reg_write || reg_read) begin
                n_cmp++;
                if (reg_write && reg_read) begin
                    n_fail++;
                    $display("FAIL strobe_onehot: write=%0b read=%0b", reg_write, reg_read);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_to(input int n);
        bit hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (count == (PTR_W + 1)'(n)) begin
                hit = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data  = $urandom;
            rd_req   = ~rd_req;
            step();
        end
        in_valid = 1'b0;
        rd_req   = 1'b0;
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL fill_timeout: count=%0d wanted %0d", count, n);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_req   = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({reg_write, reg_read, rd_ack, full, empty} !== 5'b00001 || reg_in !== '0 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: w/r/ack/full/empty=%b reg_in=%0d count=%0d expected 00001/0/0",
                     {reg_write, reg_read, rd_ack, full, empty}, reg_in, count);
        end
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({reg_write, reg_read, rd_ack} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_strobes: cycle %0d got %b expected 000", i, {reg_write, reg_read, rd_ack});
            end
        end
    endtask

    task automatic test_single;
        bit got [3];
        in_valid = 1'b1;
        in_data  = 32'd34000;
        step();
        in_valid = 1'b0;
        got[0] = reg_write;
        step();
        got[1] = reg_write;
        n_cmp++;
        if (got[LAT-1] !== 1'b1 || reg_in !== 32'd34000) begin
            n_fail++;
            $display("FAIL single_latency: reg_write after %0d edges=%b reg_in=%0d expected 1/34000",
                     LAT, got[LAT-1], reg_in);
        end
        step();
        got[2] = reg_write;
        n_cmp++;
        if ({got[0], got[1], got[2]} !== ((LAT == 2) ? 3'b010 : 3'b100) || count !== '0) begin
            n_fail++;
            $display("FAIL single_pattern: writes=%b count=%0d expected %b/0",
                     {got[0], got[1], got[2]}, count, (LAT == 2) ? 3'b010 : 3'b100);
        end
    endtask

    task automatic test_burst;
        logic [WIDTH-1:0] w [5] = '{32'd64, 32'd20000, 32'd3237, 32'd5210, 32'd21393};
        logic [6:0] got, exp_w;
        for (int i = 0; i < 7; i++) begin
            exp_w[i] = (i >= LAT - 1) && (i < LAT + 4);
            if (i < 5) begin
                in_valid = 1'b1;
                in_data  = w[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            got[i] = reg_write;
            n_cmp++;
            if (in_ready !== !full) begin
                n_fail++;
                $display("FAIL burst_in_ready: in_ready=%b full=%b", in_ready, full);
            end
        end
        n_cmp++;
        if (got !== exp_w || count !== '0) begin
            n_fail++;
            $display("FAIL burst_back_to_back: writes=%b count=%0d expected %b/0", got, count, exp_w);
        end
    endtask

    task automatic test_preempt;
        fill_to(3);
        step();
        n_cmp++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL preempt_setup: count=%0d expected 2", count);
        end
        rd_req = 1'b1;
        step();
        n_cmp++;
        if ({rd_ack, reg_read, reg_write} !== 3'b110 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL preempt_read: ack/read/write=%b count=%0d expected 110/2",
                     {rd_ack, reg_read, reg_write}, count);
        end
        rd_req = 1'b0;
        step();
        n_cmp++;
        if (reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_write1: reg_write=%b expected 1", reg_write);
        end
        step();
        n_cmp++;
        if (reg_write !== 1'b1 || count !== '0) begin
            n_fail++;
            $display("FAIL preempt_write2: reg_write=%b count=%0d expected 1/0", reg_write, count);
        end
        step();
    endtask

    task automatic test_full;
        bit drained = 1'b0;
        fill_to(4);
        n_cmp++;
        if ({full, in_ready, empty} !== 3'b100 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_flags: full/in_ready/empty=%b count=%0d expected 100/4",
                     {full, in_ready, empty}, count);
        end
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_push_refused: count=%0d expected 3", count);
        end
        for (int i = 0; i < 20; i++) begin
            if (empty) begin
                drained = 1'b1;
                break;
            end
            step();
        end
        step();
        n_cmp++;
        if (!drained || exp_q.size() != 0 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: drained=%b left=%0d reg_write=%b expected 1/0/0",
                     drained, exp_q.size(), reg_write);
        end
    endtask

    task automatic test_held_read;
        int acks = 0;
        int writes = 0;
        in_valid = 1'b1;
        in_data  = 32'd777;
        rd_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            acks   += int'(rd_ack);
            writes += int'(reg_write);
        end
        n_cmp++;
        if (acks != 1 || writes != 1) begin
            n_fail++;
            $display("FAIL held_read: acks=%0d writes=%0d expected 1/1", acks, writes);
        end
        rd_req = 1'b0;
        step();
        rd_req = 1'b1;
        step();
        n_cmp++;
        if (rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL read_after_toggle: rd_ack=%b expected 1", rd_ack);
        end
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_async_reset;
        bit hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (count == 3'd3 && reg_write) begin
                hit = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data  = $urandom;
            rd_req   = ~rd_req;
            step();
        end
        in_valid = 1'b0;
        rd_req   = 1'b0;
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL async_setup: count=%0d reg_write=%b expected 3/1", count, reg_write);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({reg_write, reg_read, rd_ack, empty} !== 4'b0001 || count !== '0) begin
            n_fail++;
            $display("FAIL async_reset: w/r/ack/empty=%b count=%0d expected 0001/0",
                     {reg_write, reg_read, rd_ack, empty}, count);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (reg_write !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_stale: cycle %0d reg_write=%b reg_in=%0d expected 0", i, reg_write, reg_in);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_preempt();
        test_full();
        test_held_read();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
